// File: rtl/add_sub_pkg.sv
// Shared constants for the add_sub ALU slice: operation encodings and the
// default datapath width.
package add_sub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam int ADD_SUB_WIDTH = 4;

endpackage : add_sub_pkg

// File: rtl/add_sub_core.sv
// Combinational two's-complement adder/subtractor built as a ripple chain of
// full-adder bit slices; subtract is A + ~B + 1.
module add_sub_core
  import add_sub_pkg::*;
#(
  parameter int WIDTH = ADD_SUB_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mode,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  logic [WIDTH-1:0] bi;
  logic [WIDTH:0]   c;

  // Inverting B and injecting mode as carry-in turns the adder into A - B.
  assign bi   = B ^ {WIDTH{mode == MODE_SUB}};
  assign c[0] = (mode == MODE_SUB);

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    assign sum[i]  = A[i] ^ bi[i] ^ c[i];
    assign c[i+1]  = (A[i] & bi[i]) | (c[i] & (A[i] ^ bi[i]));
  end

  // In subtract mode cout is the "no borrow" flag; it is deliberately not inverted.
  assign cout = c[WIDTH];
  assign ovf  = (A[WIDTH-1] == bi[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
  assign zero = ~|sum;

endmodule : add_sub_core

// File: rtl/add_sub.sv
// Registered adder/subtractor slice: one-cycle latency, synchronous active-low
// reset, output registers only written on valid input.
module add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH = ADD_SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mode,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  logic [WIDTH-1:0] core_sum;
  logic             core_cout;
  logic             core_ovf;
  logic             core_zero;

  add_sub_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .A    (A),
    .B    (B),
    .mode (mode),
    .sum  (core_sum),
    .cout (core_cout),
    .ovf  (core_ovf),
    .zero (core_zero)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      // Flags hold when idle, so undriven operands never reach the outputs.
      if (in_valid) begin
        result   <= core_sum;
        carry    <= core_cout;
        overflow <= core_ovf;
        zero     <= core_zero;
      end
    end
  end

endmodule : add_sub

// File: tb/tb_add_sub.sv
// Directed self-checking bench for add_sub (WIDTH = 4), finishing with an
// exhaustive sweep against an integer-arithmetic reference.
module tb_add_sub;
  import add_sub_pkg::*;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             mode;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             zero;

  int total_checks  = 0;
  int passed_checks = 0;

  add_sub #(
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .mode      (mode),
    .out_valid (out_valid),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag, input int r, input int c,
                           input int o, input int z, input int v);
    check({tag, ".result"},    32'(result),    32'(r));
    check({tag, ".carry"},     32'(carry),     32'(c));
    check({tag, ".overflow"},  32'(overflow),  32'(o));
    check({tag, ".zero"},      32'(zero),      32'(z));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
  endtask

  // Drive one cycle of inputs, take the edge, sample just after it.
  task automatic drive(input logic rn, input logic v, input logic [3:0] a,
                       input logic [3:0] b, input logic m);
    rst_n    = rn;
    in_valid = v;
    A        = a;
    B        = b;
    mode     = m;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sa, sb, raw, sres, er, ec, eo, ez;

    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; mode = MODE_ADD;
    @(negedge clk);

    // Reset with a valid operation pending: discarded, all outputs zero.
    drive(1'b0, 1'b1, 4'b0101, 4'b0000, MODE_ADD);
    drive(1'b0, 1'b1, 4'b0101, 4'b0000, MODE_ADD);
    check_all("reset", 0, 0, 0, 0, 0);

    // First op after release appears exactly one cycle later.
    drive(1'b1, 1'b1, 4'b0101, 4'b0001, MODE_SUB);
    check_all("sub_5_1", 4'b0100, 1, 0, 0, 1);

    // Back-to-back with in_valid held high.
    drive(1'b1, 1'b1, 4'b0101, 4'b1001, MODE_ADD);
    check_all("add_5_9", 4'b1110, 0, 0, 0, 1);
    drive(1'b1, 1'b1, 4'b0111, 4'b0011, MODE_ADD);
    check_all("add_7_3", 4'b1010, 0, 1, 0, 1);
    drive(1'b1, 1'b1, 4'b1101, 4'b0001, MODE_SUB);
    check_all("sub_d_1", 4'b1100, 1, 0, 0, 1);

    // Borrow and zero.
    drive(1'b1, 1'b1, 4'b0011, 4'b0101, MODE_SUB);
    check_all("sub_3_5", 4'b1110, 0, 0, 0, 1);
    drive(1'b1, 1'b1, 4'b0110, 4'b0110, MODE_SUB);
    check_all("sub_6_6", 4'b0000, 1, 0, 1, 1);

    // Wrap-around and signed overflow.
    drive(1'b1, 1'b1, 4'b1111, 4'b0001, MODE_ADD);
    check_all("add_f_1", 4'b0000, 1, 0, 1, 1);
    drive(1'b1, 1'b1, 4'b0000, 4'b0001, MODE_SUB);
    check_all("sub_0_1", 4'b1111, 0, 0, 0, 1);
    drive(1'b1, 1'b1, 4'b1000, 4'b0001, MODE_SUB);
    check_all("sub_8_1", 4'b0111, 1, 1, 0, 1);

    // Idle with junk operands and toggled mode: outputs hold.
    drive(1'b1, 1'b0, 4'b0110, 4'b0110, MODE_SUB);
    check_all("hold1", 4'b0111, 1, 1, 0, 0);
    drive(1'b1, 1'b0, 4'b1111, 4'b0001, MODE_ADD);
    check_all("hold2", 4'b0111, 1, 1, 0, 0);

    // Mid-stream reset wins over a valid operation.
    drive(1'b1, 1'b1, 4'b0101, 4'b1001, MODE_ADD);
    check_all("pre_rst", 4'b1110, 0, 0, 0, 1);
    drive(1'b0, 1'b1, 4'b1111, 4'b0001, MODE_ADD);
    check_all("mid_rst", 0, 0, 0, 0, 0);

    // Exhaustive sweep against signed/unsigned integer arithmetic.
    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          drive(1'b1, 1'b1, 4'(a), 4'(b), 1'(m));
          sa   = (a >= 8) ? a - 16 : a;
          sb   = (b >= 8) ? b - 16 : b;
          raw  = (m == 1) ? a - b : a + b;
          er   = raw & 15;
          ec   = (m == 1) ? int'(a >= b) : int'(a + b > 15);
          sres = (m == 1) ? sa - sb : sa + sb;
          eo   = int'(sres > 7 || sres < -8);
          ez   = int'(er == 0);
          check_all($sformatf("sweep_m%0d_a%0d_b%0d", m, a, b), er, ec, eo, ez, 1);
        end
      end
    end

    drive(1'b1, 1'b0, 4'b0000, 4'b0000, MODE_ADD);
    check("final_idle.out_valid", 32'(out_valid), 32'(0));

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule : tb_add_sub
